// File: rtl/fetch_stage_pkg.sv
// ============================================================================
// Module  : fetch_stage_pkg
// Purpose : Constants and types shared by the fetch stage, IF/ID and decode.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package fetch_stage_pkg;

  localparam int          c_pc_w          = 16;
  localparam logic [15:0] c_reset_pc      = 16'h0000;
  localparam logic [15:0] c_pc_inc        = 16'h0002;
  localparam logic [4:0]  c_halt_opcode   = 5'b00000;
  localparam logic [15:0] c_nop_instr     = 16'h0800;

  // Fetch controller states
  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_WAIT   = 2'd1,
    ST_HALTED = 2'd2
  } fetch_state_e;

  // True when the opcode field of an instruction matches the HALT encoding
  function automatic logic is_halt(input logic [15:0] instr, input logic [4:0] op);
    return (instr[15:11] == op);
  endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_stage_if.sv
// ============================================================================
// Module  : fetch_stage_if
// Purpose : Bundles the hazard inputs, instruction-memory handshake and the
//           IF/ID-facing outputs of the fetch stage.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface fetch_stage_if;
  import fetch_stage_pkg::*;

  logic              stall;
  logic              jump_hazard;
  logic [c_pc_w-1:0] redirect_pc;
  logic              imem_rd_en;
  logic [c_pc_w-1:0] imem_addr;
  logic [15:0]       imem_data;
  logic              imem_ready;
  logic [c_pc_w-1:0] pc_add_out;
  logic [15:0]       instr_out;
  logic              HALT_out;
  logic              fetch_stall;

  // Fetch stage side
  modport master (
    input  stall, jump_hazard, redirect_pc, imem_data, imem_ready,
    output imem_rd_en, imem_addr, pc_add_out, instr_out, HALT_out, fetch_stall
  );

  // Environment side (memory, hazard unit, IF/ID)
  modport slave (
    output stall, jump_hazard, redirect_pc, imem_data, imem_ready,
    input  imem_rd_en, imem_addr, pc_add_out, instr_out, HALT_out, fetch_stall
  );

endinterface

`default_nettype wire

// File: rtl/fetch_stage_pc_register.sv
// ============================================================================
// Module  : pc_register
// Purpose : Program counter storage: array of D flops with a common load
//           enable and a synchronous reset value.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module pc_register #(
  parameter int         WIDTH     = 16,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             i_load,
  input  wire logic [WIDTH-1:0] i_d,
  output logic      [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      // One flop per PC bit: reset to its RESET_VAL bit, load when enabled
      always_ff @(posedge clk) begin
        if (rst) begin
          r_q[gi] <= RESET_VAL[gi];
        end else if (i_load) begin
          r_q[gi] <= i_d[gi];
        end
      end
    end
  endgenerate

  assign o_q = r_q;

endmodule

`default_nettype wire

// File: rtl/fetch_stage.sv
// ============================================================================
// Module  : fetch_stage
// Purpose : IF stage. Owns the PC, issues instruction-memory reads over a
//           ready handshake, presents PC+inc / instruction / HALT to IF/ID,
//           and applies stalls, redirects and HALT freezing.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [15:0] RESET_PC    = c_reset_pc,
  parameter logic [15:0] PC_INC      = c_pc_inc,
  parameter logic [4:0]  HALT_OPCODE = c_halt_opcode,
  parameter logic [15:0] NOP_INSTR   = c_nop_instr
) (
  input  wire logic    clk,
  input  wire logic    rst,
  fetch_stage_if.master bus
);

  fetch_state_e      r_state;
  fetch_state_e      w_state_nxt;
  logic              r_redirect_pend;
  logic              w_redirect_pend_nxt;
  logic [c_pc_w-1:0] w_pc;
  logic [c_pc_w-1:0] w_pc_nxt;
  logic [c_pc_w-1:0] w_pc_plus;
  logic              w_pc_load;
  logic              w_active;
  logic              w_valid;
  logic              w_is_halt;

  pc_register #(
    .WIDTH     (c_pc_w),
    .RESET_VAL (RESET_PC)
  ) u_pc (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_pc_load),
    .i_d    (w_pc_nxt),
    .o_q    (w_pc)
  );

  // Incrementer wraps naturally at 2^16
  assign w_pc_plus = w_pc + PC_INC;

  // Datapath outputs: a fetch is valid only when memory answers a request
  // that has not been superseded by a redirect
  always_comb begin
    w_active  = ~rst & (r_state != ST_HALTED);
    w_valid   = w_active & bus.imem_ready & ~r_redirect_pend;
    w_is_halt = is_halt(bus.imem_data, HALT_OPCODE);

    bus.imem_rd_en  = w_active;
    bus.imem_addr   = w_pc;
    bus.pc_add_out  = w_pc_plus;
    bus.instr_out   = w_valid ? bus.imem_data : NOP_INSTR;
    bus.HALT_out    = w_valid & w_is_halt;
    bus.fetch_stall = ~w_valid;
  end

  // Next PC / next state, in priority order: redirect, drop stale, stall,
  // halted hold, HALT capture, normal advance, wait for memory
  always_comb begin
    w_state_nxt         = r_state;
    w_redirect_pend_nxt = r_redirect_pend;
    w_pc_load           = 1'b0;
    w_pc_nxt            = w_pc;

    if (bus.jump_hazard) begin
      w_pc_load = 1'b1;
      w_pc_nxt  = bus.redirect_pc;
      if ((r_state == ST_WAIT) && !bus.imem_ready) begin
        // Old request still outstanding: remember to discard its response
        w_redirect_pend_nxt = 1'b1;
        w_state_nxt         = ST_WAIT;
      end else begin
        w_redirect_pend_nxt = 1'b0;
        w_state_nxt         = ST_FETCH;
      end
    end else if (r_redirect_pend) begin
      if (bus.imem_ready) begin
        w_redirect_pend_nxt = 1'b0;
        w_state_nxt         = ST_FETCH;
      end
    end else if (bus.stall) begin
      // PC holds; the handshake still completes and its data is refetched
      if (r_state != ST_HALTED) begin
        w_state_nxt = bus.imem_ready ? ST_FETCH : ST_WAIT;
      end
    end else if (r_state == ST_HALTED) begin
      w_state_nxt = ST_HALTED;
    end else if (w_valid && w_is_halt) begin
      w_state_nxt = ST_HALTED;
    end else if (w_valid) begin
      w_pc_load   = 1'b1;
      w_pc_nxt    = w_pc_plus;
      w_state_nxt = ST_FETCH;
    end else begin
      w_state_nxt = ST_WAIT;
    end
  end

  // Controller state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= ST_FETCH;
      r_redirect_pend <= 1'b0;
    end else begin
      r_state         <= w_state_nxt;
      r_redirect_pend <= w_redirect_pend_nxt;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
// ============================================================================
// Module  : tb_fetch_stage
// Purpose : Self-checking bench for fetch_stage: directed scenarios followed
//           by randomized stall/redirect/ready/reset traffic, checked against
//           a flag-based reference model through a scoreboard queue.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fetch_stage;
  import fetch_stage_pkg::*;

  typedef struct packed {
    logic        rd_en;
    logic [15:0] addr;
    logic [15:0] pc_add;
    logic [15:0] instr;
    logic        halt;
    logic        fstall;
  } obs_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_stage_if bus ();

  fetch_stage u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Instruction memory: 256-word table, combinational read
  logic [15:0] mem [0:255];
  always_comb begin
    bus.imem_data = bus.imem_ready ? mem[bus.imem_addr[8:1]] : 16'hDEAD;
  end

  // Reference model state
  logic [15:0] m_pc;
  bit          m_halted;
  bit          m_outstanding;
  bit          m_drop;

  obs_t q_exp[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Monitor: compare each presented output against the scoreboard head
  always @(negedge clk) begin
    obs_t e;
    obs_t a;
    if (q_exp.size() > 0) begin
      e = q_exp.pop_front();
      a = '{bus.imem_rd_en, bus.imem_addr, bus.pc_add_out, bus.instr_out,
            bus.HALT_out, bus.fetch_stall};
      n_tests++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL cycle_outputs t=%0t got rd=%b addr=%h pcadd=%h instr=%h halt=%b fst=%b exp rd=%b addr=%h pcadd=%h instr=%h halt=%b fst=%b",
                 $time, a.rd_en, a.addr, a.pc_add, a.instr, a.halt, a.fstall,
                 e.rd_en, e.addr, e.pc_add, e.instr, e.halt, e.fstall);
      end
    end
  end

  // One clock of stimulus: drive inputs, predict outputs, advance the model
  task automatic cyc(input bit r, input bit s, input bit j,
                     input logic [15:0] rp, input bit rdy);
    obs_t        e;
    logic [15:0] word;
    bit          valid;
    bit          is_h;
    @(posedge clk);
    #1;
    rst             = r;
    bus.stall       = s;
    bus.jump_hazard = j;
    bus.redirect_pc = rp;
    bus.imem_ready  = rdy;

    word  = mem[m_pc[8:1]];
    valid = !r && !m_halted && rdy && !m_drop;
    is_h  = (word[15:11] == 5'd0);
    e.rd_en  = !r && !m_halted;
    e.addr   = m_pc;
    e.pc_add = m_pc + 16'd2;
    e.instr  = valid ? word : 16'h0800;
    e.halt   = valid && is_h;
    e.fstall = !valid;
    q_exp.push_back(e);

    if (r) begin
      m_pc = 16'h0000; m_halted = 0; m_outstanding = 0; m_drop = 0;
    end else if (j) begin
      if (m_outstanding && !rdy) begin
        m_drop = 1;
      end else begin
        m_outstanding = 0; m_drop = 0; m_halted = 0;
      end
      m_pc = rp;
    end else if (m_drop) begin
      if (rdy) begin
        m_drop = 0; m_outstanding = 0;
      end
    end else if (s) begin
      if (!m_halted) m_outstanding = !rdy;
    end else if (m_halted) begin
      m_halted = 1;
    end else if (valid && is_h) begin
      m_halted = 1; m_outstanding = 0;
    end else if (valid) begin
      m_pc = m_pc + 16'd2; m_outstanding = 0;
    end else begin
      m_outstanding = 1;
    end
  endtask

  initial begin
    // Memory: non-HALT words everywhere, HALT at 0x000C and sparse HALTs
    // above the directed address range
    for (int i = 0; i < 256; i++) begin
      mem[i] = {5'($urandom_range(1, 31)), 11'($urandom)};
    end
    for (int i = 0; i < 6; i++) mem[i] = 16'(16'h1111 * (i + 1));
    mem[6] = 16'h0000;
    for (int i = 40; i < 255; i++) begin
      if ($urandom_range(0, 11) == 0) mem[i] = {5'd0, 11'($urandom)};
    end

    rst = 1'b1;
    bus.stall = 1'b0; bus.jump_hazard = 1'b0;
    bus.redirect_pc = 16'h0000; bus.imem_ready = 1'b1;
    repeat (3) @(posedge clk);
    m_pc = 16'h0000; m_halted = 0; m_outstanding = 0; m_drop = 0;

    // Reset state observed
    cyc(1, 0, 0, 16'h0, 1);
    // Zero-wait streaming from 0
    cyc(0, 0, 0, 16'h0, 1);
    cyc(0, 0, 0, 16'h0, 1);
    // Stall two cycles at pc=4, then resume
    cyc(0, 1, 0, 16'h0, 1);
    cyc(0, 1, 0, 16'h0, 1);
    cyc(0, 0, 0, 16'h0, 1);
    cyc(0, 0, 0, 16'h0, 1);
    // Memory not ready three cycles at pc=8
    repeat (3) cyc(0, 0, 0, 16'h0, 0);
    cyc(0, 0, 0, 16'h0, 1);
    cyc(0, 0, 0, 16'h0, 1);
    // HALT at 0x000C, sit halted, then redirect to 0x0020
    cyc(0, 0, 0, 16'h0, 1);
    cyc(0, 0, 0, 16'h0, 1);
    cyc(0, 0, 0, 16'h0, 1);
    cyc(0, 0, 1, 16'h0020, 1);
    cyc(0, 0, 0, 16'h0, 1);
    cyc(0, 0, 0, 16'h0, 1);
    // Redirect to 0x0040 while waiting: stale response dropped
    cyc(0, 0, 0, 16'h0, 0);
    cyc(0, 0, 1, 16'h0040, 0);
    cyc(0, 0, 0, 16'h0, 0);
    cyc(0, 0, 0, 16'h0, 1);
    cyc(0, 0, 0, 16'h0, 1);
    // Reset in the middle of a wait, then wrap-around at 0xFFFE
    cyc(0, 0, 0, 16'h0, 0);
    cyc(0, 0, 0, 16'h0, 0);
    cyc(1, 0, 0, 16'h0, 0);
    cyc(0, 0, 0, 16'h0, 1);
    cyc(0, 0, 1, 16'hFFFE, 1);
    cyc(0, 0, 0, 16'h0, 1);
    cyc(0, 0, 0, 16'h0, 1);

    // Randomized traffic
    for (int k = 0; k < 2000; k++) begin
      cyc($urandom_range(0, 99) < 2,
          $urandom_range(0, 99) < 20,
          $urandom_range(0, 99) < 12,
          16'($urandom) & 16'hFFFE,
          $urandom_range(0, 99) < 70);
    end

    // Drain the scoreboard with a bounded wait
    for (int w = 0; w < 10 && q_exp.size() > 0; w++) @(negedge clk);
    @(posedge clk);
    if (q_exp.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_drain got %0d pending exp 0", q_exp.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
